// File: rtl/mc_cu.sv
// Multi-cycle MIPS control unit: sequences each instruction through
// IF/ID/EXE/MEM/WB so one ALU and one unified memory port are shared.
// Adds a memory wait-state handshake with a timeout trap, an
// illegal-instruction pulse and a retired-instruction counter.
module mc_cu #(
    parameter bit MEM_HS   = 1'b1,
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             wir,
    output logic             wpc,
    output logic             wmem,
    output logic             wreg,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic             shift,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             sext,
    output logic [3:0]       aluc,
    output logic [1:0]       pcsource,
    output logic             ill_inst,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_ERR = 3'd5;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              bus_err_q;

    // With the handshake disabled memory always answers in one cycle
    logic ready;
    assign ready = MEM_HS ? mem_ready : 1'b1;

    logic wait_limit;
    assign wait_limit = (wait_cnt == WAIT_W'(WAIT_MAX));

    logic r_type;
    assign r_type = (op == 6'b000000);

    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    assign i_add = r_type & (func == 6'b100000);
    assign i_sub = r_type & (func == 6'b100010);
    assign i_and = r_type & (func == 6'b100100);
    assign i_or  = r_type & (func == 6'b100101);
    assign i_xor = r_type & (func == 6'b100110);
    assign i_sll = r_type & (func == 6'b000000);
    assign i_srl = r_type & (func == 6'b000010);
    assign i_sra = r_type & (func == 6'b000011);
    assign i_jr  = r_type & (func == 6'b001000);

    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_lui  = (op == 6'b001111);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    logic r_alu, i_alu, is_shift, is_branch, is_mem, legal;
    assign r_alu     = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra;
    assign i_alu     = i_addi | i_andi | i_ori | i_xori | i_lui;
    assign is_shift  = i_sll | i_srl | i_sra;
    assign is_branch = i_beq | i_bne;
    assign is_mem    = i_lw | i_sw;
    assign legal     = r_alu | i_alu | is_branch | is_mem | i_jr | i_j | i_jal;

    // ALU operation for R-type and immediate instructions in EXE
    logic [3:0] alu_code;
    assign alu_code[3] = i_sra;
    assign alu_code[2] = i_sub | i_or | i_srl | i_sra | i_ori | i_lui;
    assign alu_code[1] = i_xor | i_sll | i_srl | i_sra | i_xori | i_lui;
    assign alu_code[0] = i_and | i_or | i_sll | i_srl | i_sra | i_andi | i_ori;

    // Control outputs and next state; everything held at 0 while in reset
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        iord       = 1'b0;
        wir        = 1'b0;
        wpc        = 1'b0;
        wmem       = 1'b0;
        wreg       = 1'b0;
        regrt      = 1'b0;
        m2reg      = 1'b0;
        jal        = 1'b0;
        shift      = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        sext       = 1'b0;
        aluc       = 4'b0000;
        pcsource   = 2'b00;
        ill_inst   = 1'b0;
        case (state)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (ready) begin
                    wir        = 1'b1;
                    wpc        = 1'b1;
                    next_state = S_ID;
                end else if (wait_limit) begin
                    next_state = S_ERR;
                end
            end
            S_ID: begin
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (i_j | i_jal) begin
                    wpc        = 1'b1;
                    pcsource   = 2'b11;
                    wreg       = i_jal;
                    jal        = i_jal;
                    next_state = S_IF;
                end else if (i_jr) begin
                    wpc        = 1'b1;
                    pcsource   = 2'b10;
                    next_state = S_IF;
                end else if (!legal) begin
                    ill_inst   = 1'b1;
                    next_state = S_IF;
                end else begin
                    next_state = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (is_branch) begin
                    aluc = 4'b0100;
                    sext = 1'b1;
                    if ((i_beq & z) | (i_bne & ~z)) begin
                        wpc      = 1'b1;
                        pcsource = 2'b01;
                    end
                    next_state = S_IF;
                end else if (is_mem) begin
                    alusrcb    = 2'b10;
                    sext       = 1'b1;
                    next_state = S_MEM;
                end else begin
                    alusrcb    = r_type ? 2'b00 : 2'b10;
                    shift      = is_shift;
                    sext       = i_addi;
                    aluc       = alu_code;
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = i_sw;
                if (ready) begin
                    next_state = i_sw ? S_IF : S_WB;
                end else if (wait_limit) begin
                    next_state = S_ERR;
                end
            end
            S_WB: begin
                wreg       = 1'b1;
                regrt      = ~r_type;
                m2reg      = i_lw;
                next_state = S_IF;
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: begin
                next_state = S_IF;
            end
        endcase
        if (!resetn) begin
            next_state = S_IF;
            mem_req    = 1'b0;
            iord       = 1'b0;
            wir        = 1'b0;
            wpc        = 1'b0;
            wmem       = 1'b0;
            wreg       = 1'b0;
            regrt      = 1'b0;
            m2reg      = 1'b0;
            jal        = 1'b0;
            shift      = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b00;
            sext       = 1'b0;
            aluc       = 4'b0000;
            pcsource   = 2'b00;
            ill_inst   = 1'b0;
        end
    end

    // State, wait counter, sticky bus error and retired-instruction count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IF;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
            instret   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if ((state == S_IF || state == S_MEM) && !ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (next_state == S_ERR) begin
                bus_err_q <= 1'b1;
            end
            if (next_state == S_IF && state != S_IF && state != S_ERR) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: a table of per-cycle vectors walks the
// instruction subset, then hand-written sequences cover the memory
// timeout trap and an asynchronous reset in the middle of a store.
module tb_mc_cu;

    logic        clock = 1'b0;
    logic        resetn;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        z;
    logic        mem_ready;
    logic        mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, shift, alusrca;
    logic [1:0]  alusrcb;
    logic        sext;
    logic [3:0]  aluc;
    logic [1:0]  pcsource;
    logic        ill_inst, bus_err;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    mc_cu dut (
        .clock     (clock),
        .resetn    (resetn),
        .op        (op),
        .func      (func),
        .z         (z),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .iord      (iord),
        .wir       (wir),
        .wpc       (wpc),
        .wmem      (wmem),
        .wreg      (wreg),
        .regrt     (regrt),
        .m2reg     (m2reg),
        .jal       (jal),
        .shift     (shift),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .sext      (sext),
        .aluc      (aluc),
        .pcsource  (pcsource),
        .ill_inst  (ill_inst),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    // Free-running 10-unit clock
    always #5 clock = ~clock;

    // Control word bit positions used to build expected values
    localparam logic [21:0] MREQ   = 22'(1) << 21;
    localparam logic [21:0] IORD   = 22'(1) << 20;
    localparam logic [21:0] WIR    = 22'(1) << 19;
    localparam logic [21:0] WPC    = 22'(1) << 18;
    localparam logic [21:0] WMEM   = 22'(1) << 17;
    localparam logic [21:0] WREG   = 22'(1) << 16;
    localparam logic [21:0] REGRT  = 22'(1) << 15;
    localparam logic [21:0] M2REG  = 22'(1) << 14;
    localparam logic [21:0] JAL    = 22'(1) << 13;
    localparam logic [21:0] SHIFT  = 22'(1) << 12;
    localparam logic [21:0] ASRCA  = 22'(1) << 11;
    localparam logic [21:0] B_4    = 22'(1) << 9;
    localparam logic [21:0] B_IMM  = 22'(2) << 9;
    localparam logic [21:0] B_IMM2 = 22'(3) << 9;
    localparam logic [21:0] SEXT   = 22'(1) << 8;
    localparam logic [21:0] PCS_BR = 22'(1) << 2;
    localparam logic [21:0] PCS_JR = 22'(2) << 2;
    localparam logic [21:0] PCS_J  = 22'(3) << 2;
    localparam logic [21:0] ILL    = 22'(1) << 1;
    localparam logic [21:0] BERR   = 22'(1);

    localparam logic [21:0] IF_DONE = MREQ | WIR | WPC | B_4;
    localparam logic [21:0] IF_WAIT = MREQ | B_4;
    localparam logic [21:0] ID_BASE = B_IMM2 | SEXT;

    function automatic logic [21:0] alu(input logic [3:0] c);
        return 22'(c) << 4;
    endfunction

    logic [21:0] act_cw;
    assign act_cw = {mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, shift, alusrca,
                     alusrcb, sext, aluc, pcsource, ill_inst, bus_err};

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        z;
        logic        mr;
        logic [21:0] cw;
        int          ir;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(string n, logic [5:0] o, logic [5:0] f, logic zz, logic mr,
                                   logic [21:0] cw, int ir);
        vec_t v;
        v.name = n; v.op = o; v.func = f; v.z = zz; v.mr = mr; v.cw = cw; v.ir = ir;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string n, input logic [21:0] exp_cw, input int exp_ir);
        checks++;
        if (act_cw !== exp_cw) begin
            failures++;
            $display("[TB] FAIL %s ctrl: got %06h want %06h", n, act_cw, exp_cw);
        end
        checks++;
        if (instret !== 32'(exp_ir)) begin
            failures++;
            $display("[TB] FAIL %s instret: got %0d want %0d", n, instret, exp_ir);
        end
    endtask

    // Drive inputs just after a rising edge, check mid-cycle, advance one clock
    task automatic applyStimulus(input vec_t v);
        op = v.op; func = v.func; z = v.z; mem_ready = v.mr;
        #2;
        checkOutput(v.name, v.cw, v.ir);
        @(posedge clock);
        #1;
    endtask

    // Runs one IF -> ... instruction in a few compact rows
    function automatic void fetch(string n, logic [5:0] o, logic [5:0] f, int ir);
        addVec({n, "_if"}, o, f, 1'b0, 1'b1, IF_DONE, ir);
        addVec({n, "_id"}, o, f, 1'b0, 1'b1, ID_BASE, ir);
    endfunction

    initial begin
        resetn = 1'b0; op = '0; func = '0; z = 1'b0; mem_ready = 1'b0;

        fetch("add", 6'b000000, 6'b100000, 0);
        addVec("add_exe", 6'b000000, 6'b100000, 1'b0, 1'b1, ASRCA, 0);
        addVec("add_wb",  6'b000000, 6'b100000, 1'b0, 1'b1, WREG, 0);
        fetch("sll", 6'b000000, 6'b000000, 1);
        addVec("sll_exe", 6'b000000, 6'b000000, 1'b0, 1'b1, ASRCA | SHIFT | alu(4'b0011), 1);
        addVec("sll_wb",  6'b000000, 6'b000000, 1'b0, 1'b1, WREG, 1);
        fetch("ori", 6'b001101, 6'b000000, 2);
        addVec("ori_exe", 6'b001101, 6'b000000, 1'b0, 1'b1, ASRCA | B_IMM | alu(4'b0101), 2);
        addVec("ori_wb",  6'b001101, 6'b000000, 1'b0, 1'b1, WREG | REGRT, 2);
        fetch("addi", 6'b001000, 6'b000000, 3);
        addVec("addi_exe", 6'b001000, 6'b000000, 1'b0, 1'b1, ASRCA | B_IMM | SEXT, 3);
        addVec("addi_wb",  6'b001000, 6'b000000, 1'b0, 1'b1, WREG | REGRT, 3);
        fetch("lw", 6'b100011, 6'b000000, 4);
        addVec("lw_exe",   6'b100011, 6'b000000, 1'b0, 1'b1, ASRCA | B_IMM | SEXT, 4);
        for (int i = 0; i < 3; i++)
            addVec("lw_mem_wait", 6'b100011, 6'b000000, 1'b0, 1'b0, MREQ | IORD, 4);
        addVec("lw_mem_done", 6'b100011, 6'b000000, 1'b0, 1'b1, MREQ | IORD, 4);
        addVec("lw_wb",    6'b100011, 6'b000000, 1'b0, 1'b1, WREG | REGRT | M2REG, 4);
        fetch("beq_t", 6'b000100, 6'b000000, 5);
        addVec("beq_t_exe", 6'b000100, 6'b000000, 1'b1, 1'b1,
               ASRCA | SEXT | alu(4'b0100) | WPC | PCS_BR, 5);
        fetch("beq_nt", 6'b000100, 6'b000000, 6);
        addVec("beq_nt_exe", 6'b000100, 6'b000000, 1'b0, 1'b1, ASRCA | SEXT | alu(4'b0100), 6);
        fetch("bne_t", 6'b000101, 6'b000000, 7);
        addVec("bne_t_exe", 6'b000101, 6'b000000, 1'b0, 1'b1,
               ASRCA | SEXT | alu(4'b0100) | WPC | PCS_BR, 7);
        fetch("bne_nt", 6'b000101, 6'b000000, 8);
        addVec("bne_nt_exe", 6'b000101, 6'b000000, 1'b1, 1'b1, ASRCA | SEXT | alu(4'b0100), 8);
        addVec("jal_if", 6'b000011, 6'b000000, 1'b0, 1'b1, IF_DONE, 9);
        addVec("jal_id", 6'b000011, 6'b000000, 1'b0, 1'b1, ID_BASE | WPC | WREG | JAL | PCS_J, 9);
        addVec("j_if",   6'b000010, 6'b000000, 1'b0, 1'b1, IF_DONE, 10);
        addVec("j_id",   6'b000010, 6'b000000, 1'b0, 1'b1, ID_BASE | WPC | PCS_J, 10);
        addVec("jr_if",  6'b000000, 6'b001000, 1'b0, 1'b1, IF_DONE, 11);
        addVec("jr_id",  6'b000000, 6'b001000, 1'b0, 1'b1, ID_BASE | WPC | PCS_JR, 11);
        addVec("illop_if", 6'b111111, 6'b000000, 1'b0, 1'b1, IF_DONE, 12);
        addVec("illop_id", 6'b111111, 6'b000000, 1'b0, 1'b1, ID_BASE | ILL, 12);
        fetch("sw", 6'b101011, 6'b000000, 13);
        addVec("sw_exe",  6'b101011, 6'b000000, 1'b0, 1'b1, ASRCA | B_IMM | SEXT, 13);
        addVec("sw_wait", 6'b101011, 6'b000000, 1'b0, 1'b0, MREQ | IORD | WMEM, 13);
        addVec("sw_done", 6'b101011, 6'b000000, 1'b0, 1'b1, MREQ | IORD | WMEM, 13);
        addVec("sub_if_wait", 6'b000000, 6'b100010, 1'b0, 1'b0, IF_WAIT, 14);
        fetch("sub", 6'b000000, 6'b100010, 14);
        addVec("sub_exe", 6'b000000, 6'b100010, 1'b0, 1'b1, ASRCA | alu(4'b0100), 14);
        addVec("sub_wb",  6'b000000, 6'b100010, 1'b0, 1'b1, WREG, 14);
        fetch("lui", 6'b001111, 6'b000000, 15);
        addVec("lui_exe", 6'b001111, 6'b000000, 1'b0, 1'b1, ASRCA | B_IMM | alu(4'b0110), 15);
        addVec("lui_wb",  6'b001111, 6'b000000, 1'b0, 1'b1, WREG | REGRT, 15);
        addVec("illfn_if_wait", 6'b000000, 6'b111111, 1'b0, 1'b0, IF_WAIT, 16);
        addVec("illfn_if", 6'b000000, 6'b111111, 1'b0, 1'b1, IF_DONE, 16);
        addVec("illfn_id", 6'b000000, 6'b111111, 1'b0, 1'b1, ID_BASE | ILL, 16);
        addVec("final_if", 6'b000000, 6'b000000, 1'b0, 1'b0, IF_WAIT, 17);

        // Reset state
        #3;
        checkOutput("reset_hold", 22'd0, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Memory timeout: 16 stalled cycles in IF lead to ERR
        resetn = 1'b0;
        #1;
        checkOutput("reset_pulse", 22'd0, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        op = '0; func = 6'b100000; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #2;
            checkOutput($sformatf("timeout_if_%0d", i), IF_WAIT, 0);
            @(posedge clock);
            #1;
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput($sformatf("err_hold_%0d", i), BERR, 0);
            @(posedge clock);
            #1;
        end
        resetn = 1'b0;
        #1;
        checkOutput("err_reset", 22'd0, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        mem_ready = 1'b0;
        #2;
        checkOutput("err_recover_if", IF_WAIT, 0);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a store abandons it
        op = 6'b101011; func = '0; mem_ready = 1'b1;
        #2; checkOutput("rsw_if", IF_DONE, 0);
        @(posedge clock); #1;
        #2; checkOutput("rsw_id", ID_BASE, 0);
        @(posedge clock); #1;
        #2; checkOutput("rsw_exe", ASRCA | B_IMM | SEXT, 0);
        @(posedge clock); #1;
        mem_ready = 1'b0;
        #2; checkOutput("rsw_mem", MREQ | IORD | WMEM, 0);
        resetn = 1'b0;
        #1;
        checkOutput("rsw_reset", 22'd0, 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        #2;
        checkOutput("rsw_back_if", IF_WAIT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
